// File: rtl/io_page_pkg.sv
// io_page_pkg: shared constants for the I/O page strobe decoder.
//   Strobe index map of the 1k I/O page plus default page base and
//   watchdog timing. No ports.
package io_page_pkg;

  typedef enum logic [2:0] {
    STB_UART   = 3'd0,
    STB_HSLD   = 3'd1,
    STB_VSLD   = 3'd2,
    STB_INTACK = 3'd3,
    STB_WDOG   = 3'd4,
    STB_OUT0   = 3'd5,
    STB_OUT1   = 3'd6,
    STB_CRAM   = 3'd7
  } stb_idx_e;

  localparam logic [15:0] DEF_PAGE_BASE  = 16'h9C00;
  localparam int          DEF_WDOG_LIMIT = 8;
  localparam int          DEF_RST_CYCLES = 16;

endpackage

// File: rtl/io_page_strobe_decoder_if.sv
// io_page_strobe_decoder_if: bus-side bundle of the I/O page decoder.
//   master: drives ce2H, ce2Hd, BA, BRWn, vblank, wdog_en; observes outputs.
//   slave : the decoder; receives the bus, drives wr_stb, wr_idx, rd_sel,
//           wdog_rst, wdog_cnt.
interface io_page_strobe_decoder_if #(
  parameter int ADDR_W    = 16,
  parameter int PAGE_BITS = 10,
  parameter int SEL_BITS  = 3,
  parameter int WDOG_W    = 4
);
  localparam int NUM_STB = 2**SEL_BITS;
  localparam int IDX_W   = PAGE_BITS - SEL_BITS;

  logic                ce2H;
  logic                ce2Hd;
  logic [ADDR_W-1:0]   BA;
  logic                BRWn;
  logic                vblank;
  logic                wdog_en;
  logic [NUM_STB-1:0]  wr_stb;
  logic [IDX_W-1:0]    wr_idx;
  logic [NUM_STB-1:0]  rd_sel;
  logic                wdog_rst;
  logic [WDOG_W-1:0]   wdog_cnt;

  modport master (
    output ce2H, ce2Hd, BA, BRWn, vblank, wdog_en,
    input  wr_stb, wr_idx, rd_sel, wdog_rst, wdog_cnt
  );

  modport slave (
    input  ce2H, ce2Hd, BA, BRWn, vblank, wdog_en,
    output wr_stb, wr_idx, rd_sel, wdog_rst, wdog_cnt
  );
endinterface

// File: rtl/watchdog_timer.sv
// watchdog_timer: frame watchdog. Counts vblank rising edges while enabled;
//   a kick clears the count. Reaching WDOG_LIMIT edges without a kick
//   launches a wdog_rst pulse of exactly RST_CYCLES clks.
//   Ports: clk, reset (async high), i_kick, i_vblank, i_wdog_en,
//          o_wdog_rst, o_wdog_cnt.
//   WDOG_LIMIT must be in 1..2**WDOG_W-1, RST_CYCLES >= 1.
module watchdog_timer
  import io_page_pkg::*;
#(
  parameter int WDOG_W     = 4,
  parameter int WDOG_LIMIT = DEF_WDOG_LIMIT,
  parameter int RST_CYCLES = DEF_RST_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_kick,
  input  logic              i_vblank,
  input  logic              i_wdog_en,
  output logic              o_wdog_rst,
  output logic [WDOG_W-1:0] o_wdog_cnt
);
  localparam int TMR_W = $clog2(RST_CYCLES + 1);

  logic              r_vblank_d;
  logic [WDOG_W-1:0] r_cnt;
  logic [TMR_W-1:0]  r_timer;
  logic              r_rst;
  logic              w_vb_rise;

  assign w_vb_rise = i_vblank & ~r_vblank_d;

  // Loading the timer leaves r_rst low for that edge; each following edge
  // with a non-zero timer holds r_rst high, giving RST_CYCLES clks of pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vblank_d <= 1'b1;  // a vblank held across release is not an edge
      r_cnt      <= '0;
      r_timer    <= '0;
      r_rst      <= 1'b0;
    end else begin
      r_vblank_d <= i_vblank;
      r_rst      <= 1'b0;
      if (r_timer != '0) begin
        r_timer <= r_timer - 1'b1;
        r_rst   <= 1'b1;
        r_cnt   <= '0;
      end else if (!i_wdog_en || i_kick) begin
        r_cnt <= '0;
      end else if (w_vb_rise) begin
        if (r_cnt == WDOG_W'(WDOG_LIMIT - 1)) begin
          r_cnt   <= '0;
          r_timer <= TMR_W'(RST_CYCLES);
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_wdog_rst = r_rst;
  assign o_wdog_cnt = r_cnt;
endmodule

// File: rtl/io_page_strobe_decoder.sv
// io_page_strobe_decoder: registered 6502 I/O page decoder.
//   Decodes one 2**PAGE_BITS page at PAGE_BASE into 2**SEL_BITS strobes:
//   a single-clk one-hot write strobe per bus cycle with captured low
//   address bits, a registered one-hot read select, and a frame watchdog
//   kicked by the WDOG_IDX write strobe.
//   Ports: clk, reset (async high), bus (io_page_strobe_decoder_if.slave).
module io_page_strobe_decoder
  import io_page_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter int                PAGE_BITS  = 10,
  parameter logic [ADDR_W-1:0] PAGE_BASE  = ADDR_W'(DEF_PAGE_BASE),
  parameter int                SEL_BITS   = 3,
  parameter int                WDOG_IDX   = int'(STB_WDOG),
  parameter int                WDOG_W     = 4,
  parameter int                WDOG_LIMIT = DEF_WDOG_LIMIT,
  parameter int                RST_CYCLES = DEF_RST_CYCLES
) (
  input  logic                     clk,
  input  logic                     reset,
  io_page_strobe_decoder_if.slave  bus
);
  localparam int NUM_STB = 2**SEL_BITS;
  localparam int IDX_W   = PAGE_BITS - SEL_BITS;

  logic                w_hit;
  logic [SEL_BITS-1:0] w_sel;
  logic [NUM_STB-1:0]  w_onehot;
  logic                w_wr_fire;
  logic                w_wdog_rst;
  logic [WDOG_W-1:0]   w_wdog_cnt;

  logic [NUM_STB-1:0]  r_wr_stb;
  logic [IDX_W-1:0]    r_wr_idx;
  logic [NUM_STB-1:0]  r_rd_sel;
  logic                r_armed;

  assign w_hit     = (bus.BA[ADDR_W-1:PAGE_BITS] == PAGE_BASE[ADDR_W-1:PAGE_BITS]);
  assign w_sel     = bus.BA[PAGE_BITS-1 -: SEL_BITS];
  assign w_onehot  = NUM_STB'(1) << w_sel;
  // armed gates repeated/held ce2Hd so only one strobe leaves per bus cycle
  assign w_wr_fire = bus.ce2Hd & w_hit & ~bus.BRWn & r_armed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_stb <= '0;
      r_wr_idx <= '0;
      r_rd_sel <= '0;
      r_armed  <= 1'b1;
    end else begin
      r_wr_stb <= '0;
      if (w_wr_fire) begin
        r_wr_stb <= w_onehot;
        r_wr_idx <= bus.BA[IDX_W-1:0];
      end
      // ce2H re-arms even when it coincides with a firing ce2Hd
      r_armed <= bus.ce2H | (r_armed & ~w_wr_fire);
      if (bus.ce2H)
        r_rd_sel <= (w_hit & bus.BRWn) ? w_onehot : '0;
    end
  end

  watchdog_timer #(
    .WDOG_W     (WDOG_W),
    .WDOG_LIMIT (WDOG_LIMIT),
    .RST_CYCLES (RST_CYCLES)
  ) u_wdog (
    .clk        (clk),
    .reset      (reset),
    .i_kick     (r_wr_stb[WDOG_IDX]),
    .i_vblank   (bus.vblank),
    .i_wdog_en  (bus.wdog_en),
    .o_wdog_rst (w_wdog_rst),
    .o_wdog_cnt (w_wdog_cnt)
  );

  assign bus.wr_stb   = r_wr_stb;
  assign bus.wr_idx   = r_wr_idx;
  assign bus.rd_sel   = r_rd_sel;
  assign bus.wdog_rst = w_wdog_rst;
  assign bus.wdog_cnt = w_wdog_cnt;
endmodule

// File: doc/io_page_strobe_decoder.md
Name: io_page_strobe_decoder

Overview:
- Parametrised, registered successor to the combinational I/O page decoder.
- Decodes one 2^PAGE_BITS-byte I/O page of the 6502 bus into NUM_STB one-hot select lines.
- Issues exactly one single-clk write strobe per bus cycle, plus a registered index.
- Holds a frame-based watchdog that emits a timed reset pulse when the WDOG strobe is not written within WDOG_LIMIT frames.

Parameters:
- ADDR_W, 16, CPU address width.
- PAGE_BITS, 10, log2 of page size (1k page).
- PAGE_BASE, 16'h9C00, page base; only bits [ADDR_W-1:PAGE_BITS] are compared.
- SEL_BITS, 3, select field width; NUM_STB = 2**SEL_BITS.
- WDOG_IDX, 4, strobe index that kicks the watchdog.
- WDOG_W, 4, watchdog counter width.
- WDOG_LIMIT, 8, vblank edges without a kick before reset; must satisfy 1 <= WDOG_LIMIT <= 2**WDOG_W-1.
- RST_CYCLES, 16, width of the reset pulse in clk cycles; must be >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ce2H  in  1  clock enable marking the start of a bus cycle.
- ce2Hd  in  1  clock enable marking the write-data-valid point.
- BA  in  ADDR_W  CPU address bus.
- BRWn  in  1  1 = read, 0 = write.
- vblank  in  1  vertical blank level, clk-synchronous.
- wdog_en  in  1  watchdog enable.
- wr_stb  out  NUM_STB  one-hot write strobe, one clk wide.
- wr_idx  out  PAGE_BITS-SEL_BITS  BA low bits, captured with the strobe.
- rd_sel  out  NUM_STB  registered one-hot read select.
- wdog_rst  out  1  watchdog reset pulse.
- wdog_cnt  out  WDOG_W  current frame count, for debug.

Behaviour:
- Reset (async, active-high):
  - wr_stb=0, wr_idx=0, rd_sel=0, wdog_rst=0, wdog_cnt=0.
  - armed=1.
  - vblank_d=1, so no spurious edge is counted after release.
- Decode:
  - hit = (BA[ADDR_W-1:PAGE_BITS] == PAGE_BASE[ADDR_W-1:PAGE_BITS]).
  - sel = BA[PAGE_BITS-1:PAGE_BITS-SEL_BITS].
- Write strobe:
  - Fires on the clk edge where ce2Hd & hit & ~BRWn & armed.
  - That edge sets wr_stb[sel]=1, wr_idx=BA[PAGE_BITS-SEL_BITS-1:0], armed=0.
  - Next clk: wr_stb=0. Latency 1 clk from the qualifying edge; width exactly 1 clk.
  - armed returns to 1 on any clk edge with ce2H=1.
  - ce2Hd held high for several clks, or repeated within one bus cycle, produces only one strobe.
  - ce2H and ce2Hd in the same clk: the strobe fires (using the current armed value), then armed=1.
- wr_idx: holds its last value between strobes.
- Read select:
  - On a clk edge with ce2H=1: rd_sel = onehot(sel) if hit & BRWn, else 0.
  - Otherwise rd_sel holds its value.
- Watchdog:
  - vb_rise = vblank & ~vblank_d; vblank_d is updated every clk.
  - kick = wr_stb[WDOG_IDX] (the registered strobe).
  - Priority per clk, highest first:
    1. rst_timer != 0 (pulse active): decrement rst_timer; wdog_rst=1; wdog_cnt=0; kicks and edges ignored.
    2. wdog_en=0: wdog_cnt=0.
    3. kick: wdog_cnt=0. Kick beats a simultaneous vb_rise.
    4. vb_rise and wdog_cnt==WDOG_LIMIT-1: wdog_cnt=0; rst_timer=RST_CYCLES; wdog_rst=1 from the next clk.
    5. vb_rise: wdog_cnt+1.
  - wdog_rst is high for exactly RST_CYCLES clks, then drops to 0.
  - The pulse completes even if wdog_en falls mid-pulse.
  - Asserting reset mid-pulse aborts the pulse immediately.
- Timing: all outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package io_page_pkg:
  - Strobe indices: STB_UART=0, STB_HSLD=1, STB_VSLD=2, STB_INTACK=3, STB_WDOG=4, STB_OUT0=5, STB_OUT1=6, STB_CRAM=7.
  - Default PAGE_BASE=16'h9C00.
  - Default WDOG_LIMIT and RST_CYCLES.
- Sub-module watchdog_timer, parameters WDOG_W / WDOG_LIMIT / RST_CYCLES.
  - Inputs: kick, vblank, wdog_en.
  - Outputs: wdog_rst, wdog_cnt.
  - Owns vblank_d, the counter and rst_timer.
- Top level holds the decode, arm flag, strobe registers and rd_sel.

Test Plan:
- Write to 9E80: BRWn=0, ce2H pulse, then ce2Hd held 3 clks -> wr_stb=8'h20 for exactly 1 clk, 1 clk after the first ce2Hd edge; wr_idx=0; no second pulse.
- Read 9F85: BRWn=1, ce2H=1 -> rd_sel=8'h80 next clk; then BA=8000 with ce2H -> rd_sel=0; a write at 9F85 leaves wr_stb=0 for a read cycle.
- Write to 9C05: wr_stb=8'h01, wr_idx=5. Write to 9BFF and to A000 -> no strobe.
- wdog_en=1, no kicks, 8 vblank rising edges -> wdog_cnt goes 1..7, then 0; wdog_rst high exactly 16 clks starting 1 clk after the 8th edge.
- Kick (write to 9E00) in the same clk as the 7th vb_rise -> wdog_cnt=0 and no wdog_rst; a vblank held high across reset release does not increment the count.
- Async reset asserted in the 5th clk of a wdog_rst pulse -> all outputs 0 immediately, with no re-pulse after release; wdog_en=0 with 20 vblank edges -> wdog_cnt stays 0.
